// File: rtl/adc_trig_capture_ctrl_if.sv
// ADC-side RAM write port driven by the triggered capture sequencer.
// master: the sequencer (drives the port); slave: soc_ram ADC write port.
interface adc_trig_capture_ctrl_if #(
   parameter int ADDR_W = 13
);
   logic              adc_we_o;
   logic [31:0]       adc_data_o;
   logic [ADDR_W-1:0] adc_addr_o;

   modport master (output adc_we_o, output adc_data_o, output adc_addr_o);
   modport slave  (input  adc_we_o, input  adc_data_o, input  adc_addr_o);
endinterface

// File: rtl/adc_trig_capture_ctrl.sv
// Triggered capture sequencer: runs the soc_ram ADC write port as a circular
// pre-trigger buffer inside a fixed RAM window [BASE_ADDR, BASE_ADDR+DEPTH).
// Optional macro ADC_TRIG_TIMEOUT_EN adds an auto-trigger timeout counter in
// ARMED; without it csr_tmo_i is accepted but ignored.
module adc_trig_capture_ctrl #(
   parameter int                ADDR_W    = 13,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 13'h400,
   parameter int                DEPTH     = 4096,
   parameter int                TMO_W     = 24,
   localparam int               PW        = $clog2(DEPTH)
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst,
   input  logic [31:0]             adc_sample_in,
   input  logic                    csr_start_i,
   input  logic                    csr_abort_i,
   input  logic                    csr_force_i,
   input  logic [PW-1:0]           csr_pretrig_i,
   input  logic [11:0]             csr_level_i,
   input  logic                    csr_edge_i,
   input  logic [TMO_W-1:0]        csr_tmo_i,
   output logic                    csr_busy_o,
   output logic                    csr_done_o,
   output logic [PW-1:0]           csr_trig_idx_o,
   output logic [2:0]              csr_state_o,
   adc_trig_capture_ctrl_if.master ram_wr
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_PRE   = 3'd1;
   localparam logic [2:0] ST_ARMED = 3'd2;
   localparam logic [2:0] ST_POST  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [PW-1:0]     wptr_q, wptr_d;
   logic [PW-1:0]     cnt_q, cnt_d;
   logic [PW-1:0]     pretrig_q, pretrig_d;
   logic [11:0]       level_q, level_d;
   logic              fall_q, fall_d;
   logic [11:0]       prev_ch0_q, prev_ch0_d;
   logic [PW-1:0]     trig_idx_q, trig_idx_d;
   logic              we_q, we_d;
   logic [31:0]       data_q, data_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              write_s;
   logic              restart_s;
   logic              hit_s;
   logic              tmo_hit_s;
   logic              trig_s;
   logic [11:0]       cur_ch0_s;
   logic [PW-1:0]     post_last_s;

   // Threshold crossing of ch0 between the previous and the current sample
   always_comb begin
      cur_ch0_s  = adc_sample_in[11:0];
      prev_ch0_d = adc_sample_in[11:0];
      if (fall_q) begin
         hit_s = (prev_ch0_q >= level_q) && (cur_ch0_s < level_q);
      end else begin
         hit_s = (prev_ch0_q < level_q) && (cur_ch0_s >= level_q);
      end
   end

`ifdef ADC_TRIG_TIMEOUT_EN
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

   // Auto-trigger counter: held at zero outside ARMED, counts ARMED cycles
   always_comb begin
      if (state_q == ST_ARMED) begin
         tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end else begin
         tmo_cnt_d = {TMO_W{1'b0}};
      end
      tmo_hit_s = (state_q == ST_ARMED) && (csr_tmo_i != {TMO_W{1'b0}}) &&
                  (tmo_cnt_q == csr_tmo_i);
   end

   // Timeout counter register
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         tmo_cnt_q <= {TMO_W{1'b0}};
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end
`else
   logic tmo_unused_s;
   assign tmo_unused_s = ^csr_tmo_i;
   assign tmo_hit_s    = 1'b0;
`endif

   // Force and timeout act exactly like a threshold crossing; only ARMED uses it
   assign trig_s = hit_s | csr_force_i | tmo_hit_s;

   // POST writes DEPTH-1-pretrig samples; with DEPTH a power of two that is ~pretrig
   assign post_last_s = ~pretrig_q - PW'(1);

   // Sequencer: abort dominates everything, start only from IDLE/DONE
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pretrig_d  = pretrig_q;
      level_d    = level_q;
      fall_d     = fall_q;
      trig_idx_d = trig_idx_q;
      write_s    = 1'b0;
      restart_s  = 1'b0;
      if (csr_abort_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (csr_start_i) begin
                  restart_s = 1'b1;
                  pretrig_d = csr_pretrig_i;
                  level_d   = csr_level_i;
                  fall_d    = csr_edge_i;
                  cnt_d     = {PW{1'b0}};
                  if (csr_pretrig_i == {PW{1'b0}}) begin
                     state_d = ST_ARMED;
                  end else begin
                     state_d = ST_PRE;
                  end
               end else begin
                  state_d = state_q;
               end
            end
            ST_PRE: begin
               write_s = 1'b1;
               if (cnt_q == pretrig_q - PW'(1)) begin
                  state_d = ST_ARMED;
                  cnt_d   = {PW{1'b0}};
               end else begin
                  cnt_d = cnt_q + PW'(1);
               end
            end
            ST_ARMED: begin
               write_s = 1'b1;
               if (trig_s) begin
                  trig_idx_d = wptr_q;
                  cnt_d      = {PW{1'b0}};
                  if (pretrig_q == {PW{1'b1}}) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_POST;
                  end
               end else begin
                  state_d = ST_ARMED;
               end
            end
            ST_POST: begin
               write_s = 1'b1;
               if (cnt_q == post_last_s) begin
                  state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_q + PW'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // RAM write port and circular write pointer
   always_comb begin
      if (write_s) begin
         we_d   = 1'b1;
         data_d = adc_sample_in;
         addr_d = BASE_ADDR + ADDR_W'(wptr_q);
      end else begin
         we_d   = 1'b0;
         data_d = data_q;
         addr_d = addr_q;
      end
      if (restart_s) begin
         wptr_d = {PW{1'b0}};
      end else if (write_s) begin
         wptr_d = wptr_q + PW'(1);
      end else begin
         wptr_d = wptr_q;
      end
      busy_d = (state_d == ST_PRE) || (state_d == ST_ARMED) || (state_d == ST_POST);
      done_d = (state_d == ST_DONE);
   end

   // All state, datapath and status registers
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q    <= ST_IDLE;
         wptr_q     <= {PW{1'b0}};
         cnt_q      <= {PW{1'b0}};
         pretrig_q  <= {PW{1'b0}};
         level_q    <= 12'h000;
         fall_q     <= 1'b0;
         prev_ch0_q <= 12'h000;
         trig_idx_q <= {PW{1'b0}};
         we_q       <= 1'b0;
         data_q     <= 32'h0000_0000;
         addr_q     <= {ADDR_W{1'b0}};
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wptr_q     <= wptr_d;
         cnt_q      <= cnt_d;
         pretrig_q  <= pretrig_d;
         level_q    <= level_d;
         fall_q     <= fall_d;
         prev_ch0_q <= prev_ch0_d;
         trig_idx_q <= trig_idx_d;
         we_q       <= we_d;
         data_q     <= data_d;
         addr_q     <= addr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign csr_busy_o        = busy_q;
   assign csr_done_o        = done_q;
   assign csr_trig_idx_o    = trig_idx_q;
   assign csr_state_o       = state_q;
   assign ram_wr.adc_we_o   = we_q;
   assign ram_wr.adc_data_o = data_q;
   assign ram_wr.adc_addr_o = addr_q;

endmodule

// File: tb/tb_adc_trig_capture_ctrl.sv
// Self-checking bench for adc_trig_capture_ctrl. Sample streams are generated
// with $urandom; the expected trigger write, write count and window contents
// come from a sample-history model of the capture rules.
module tb_adc_trig_capture_ctrl;
   localparam int          ADDR_W = 13;
   localparam int          DEPTH  = 4096;
   localparam logic [12:0] BASE   = 13'h400;
   localparam int          NS     = 16384;
`ifdef ADC_TRIG_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic [31:0] adc_sample_in;
   logic        csr_start_i, csr_abort_i, csr_force_i, csr_edge_i;
   logic [11:0] csr_pretrig_i, csr_level_i;
   logic [23:0] csr_tmo_i;
   logic        csr_busy_o, csr_done_o;
   logic [11:0] csr_trig_idx_o;
   logic [2:0]  csr_state_o;

   always #5 sys_clk = ~sys_clk;

   adc_trig_capture_ctrl_if #(.ADDR_W(ADDR_W)) wr_if ();

   adc_trig_capture_ctrl #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .DEPTH(DEPTH), .TMO_W(24)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .adc_sample_in(adc_sample_in),
      .csr_start_i(csr_start_i), .csr_abort_i(csr_abort_i), .csr_force_i(csr_force_i),
      .csr_pretrig_i(csr_pretrig_i), .csr_level_i(csr_level_i), .csr_edge_i(csr_edge_i),
      .csr_tmo_i(csr_tmo_i), .csr_busy_o(csr_busy_o), .csr_done_o(csr_done_o),
      .csr_trig_idx_o(csr_trig_idx_o), .csr_state_o(csr_state_o), .ram_wr(wr_if)
   );

   logic [31:0] samp [NS];
   logic [31:0] samp_pre;
   logic [31:0] mem [8192];
   int          checks = 0, passes = 0, fails = 0;
   int          wr_cnt, seq_err;
   bit          saw_wrap;
   logic [12:0] last_addr;
   logic [11:0] exp_trig = 12'h000;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one clock; observe the write port 1 time unit after the edge and keep a RAM image
   task automatic tick();
      @(posedge sys_clk);
      #1;
      if (wr_if.adc_we_o === 1'b1) begin
         if (wr_cnt >= NS || wr_if.adc_addr_o !== BASE + 13'(wr_cnt % DEPTH) ||
             wr_if.adc_data_o !== samp[wr_cnt]) seq_err++;
         if (last_addr == 13'h13FF && wr_if.adc_addr_o == 13'h0400) saw_wrap = 1'b1;
         last_addr = wr_if.adc_addr_o;
         mem[wr_if.adc_addr_o] = wr_if.adc_data_o;
         wr_cnt++;
      end
   endtask

   function automatic logic [31:0] mk(input logic [11:0] c0, input logic [11:0] c1);
      return {4'h0, c1, 4'h0, c0};
   endfunction

   task automatic fill_rand(input int from, input int to, input int lo, input int hi);
      for (int j = from; j < to; j++)
         samp[j] = mk(12'($urandom_range(hi, lo)), 12'($urandom_range(4095, 0)));
   endtask

   // Write n carries samp[n]; the first write able to trigger is n = pretrig.
   function automatic int predict(input int pt, input logic [11:0] lvl, input logic edg,
                                  input int force_at, input int tmo);
      for (int j = pt; j < NS; j++) begin
         int p, c;
         p = (j == 0) ? int'(samp_pre[11:0]) : int'(samp[j-1][11:0]);
         c = int'(samp[j][11:0]);
         if (!edg && p < int'(lvl) && c >= int'(lvl)) return j;
         if (edg && p >= int'(lvl) && c < int'(lvl)) return j;
         if (j == force_at) return j;
         if (TMO_EN && tmo != 0 && (j - pt) == tmo) return j;
      end
      return -1;
   endfunction

   function automatic int exp_state(input int j, input int pt, input int jt, input int w);
      if (j < pt) return 1;
      if (jt < 0 || j <= jt) return 2;
      if (j < w) return 3;
      return 4;
   endfunction

   task automatic run_capture(input string tag, input int pt, input logic [11:0] lvl,
                              input logic edg, input int force_at, input int tmo,
                              input int abort_at, input bit use_rst, input int budget);
      int jt, w, j, err, jl;
      bit got_done;
      jt = predict(pt, lvl, edg, force_at, tmo);
      w  = (jt < 0) ? -1 : jt + DEPTH - pt;
      for (int i = 0; i < DEPTH; i++) mem[BASE + 13'(i)] = 'x;
      wr_cnt = 0; seq_err = 0; saw_wrap = 1'b0; last_addr = 13'h0000;
      csr_pretrig_i = 12'(pt); csr_level_i = lvl; csr_edge_i = edg; csr_tmo_i = 24'(tmo);
      adc_sample_in = samp_pre; csr_start_i = 1'b1;
      tick();
      csr_start_i = 1'b0;
      chk({tag, ".start_state"}, csr_state_o, (pt == 0) ? 2 : 1);
      chk({tag, ".start_we"}, wr_if.adc_we_o, 1'b0);
      got_done = 1'b0;
      j = 0;
      while (j < budget && !got_done) begin
         adc_sample_in = samp[j];
         csr_force_i = (j == force_at);
         if (j == abort_at) begin
            chk({tag, ".pre_abort_state"}, csr_state_o, exp_state(j, pt, jt, w));
            if (use_rst) sys_rst = 1'b1;
            else begin csr_abort_i = 1'b1; csr_start_i = 1'b1; end
         end
         tick();
         csr_force_i = 1'b0; csr_abort_i = 1'b0; csr_start_i = 1'b0; sys_rst = 1'b0;
         if (j == 0 && abort_at != 0) begin
            chk({tag, ".first_we"}, wr_if.adc_we_o, 1'b1);
            chk({tag, ".first_addr"}, wr_if.adc_addr_o, BASE);
         end
         if (j == abort_at) begin
            if (use_rst) exp_trig = 12'h000;
            else if (jt >= 0 && j > jt) exp_trig = 12'(jt % DEPTH);
            chk({tag, ".abort_state"}, csr_state_o, 3'd0);
            chk({tag, ".abort_we"}, wr_if.adc_we_o, 1'b0);
            chk({tag, ".abort_done"}, csr_done_o, 1'b0);
            chk({tag, ".abort_busy"}, csr_busy_o, 1'b0);
            chk({tag, ".abort_trig_idx"}, csr_trig_idx_o, exp_trig);
            return;
         end
         got_done = csr_done_o;
         j++;
      end
      exp_trig = 12'(jt % DEPTH);
      chk({tag, ".done_reached"}, got_done, 1'b1);
      chk({tag, ".write_count"}, wr_cnt, w);
      chk({tag, ".write_seq_errs"}, seq_err, 0);
      chk({tag, ".trig_idx"}, csr_trig_idx_o, exp_trig);
      chk({tag, ".trig_sample"}, mem[BASE + 13'(jt % DEPTH)], samp[jt]);
      err = 0;
      for (int i = 1; i <= pt; i++)
         if (mem[BASE + 13'((jt - i) % DEPTH)] !== samp[jt - i]) err++;
      chk({tag, ".pretrig_contig_errs"}, err, 0);
      err = 0;
      for (int o = 0; o < DEPTH; o++) begin
         jl = o + DEPTH * ((w - 1 - o) / DEPTH);
         if (mem[BASE + 13'(o)] !== samp[jl]) err++;
      end
      chk({tag, ".window_errs"}, err, 0);
      adc_sample_in = samp[j];
      tick();
      chk({tag, ".done_we"}, wr_if.adc_we_o, 1'b0);
      chk({tag, ".done_state"}, csr_state_o, 3'd4);
      chk({tag, ".done_flag"}, csr_done_o, 1'b1);
      chk({tag, ".done_busy"}, csr_busy_o, 1'b0);
   endtask

   initial begin
      sys_rst = 1'b1; csr_start_i = 1'b1; csr_abort_i = 1'b0; csr_force_i = 1'b0;
      csr_edge_i = 1'b0; csr_pretrig_i = 12'h000; csr_level_i = 12'h000;
      csr_tmo_i = 24'h0; adc_sample_in = 32'h0;
      wr_cnt = 0; seq_err = 0; saw_wrap = 1'b0; last_addr = 13'h0000;

      // 1: reset held with start asserted
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("rst.state", csr_state_o, 3'd0);
         chk("rst.we", wr_if.adc_we_o, 1'b0);
         chk("rst.done", csr_done_o, 1'b0);
      end
      sys_rst = 1'b0; csr_start_i = 1'b0;
      tick();
      chk("idle.busy", csr_busy_o, 1'b0);

      // 2: ramp with rising trigger at ch0 = 0x800
      samp_pre = mk(12'h000, 12'h000);
      for (int j = 0; j < NS; j++) samp[j] = mk(12'(j), 12'($urandom_range(4095, 0)));
      run_capture("ramp", 16, 12'h800, 1'b0, -1, 0, -1, 1'b0, 7000);

      // 3: pretrig 0, software force 10 writes in
      samp_pre = mk(12'h100, 12'h000);
      fill_rand(0, NS, 0, 12'h7FF);
      run_capture("force", 0, 12'h800, 1'b0, 10, 0, -1, 1'b0, 4300);

      // 4: trigger held off ~5000 cycles, window wraps
      samp_pre = mk(12'h000, 12'h000);
      fill_rand(0, 5100, 0, 12'h7FF);
      fill_rand(5100, NS, 12'h800, 12'hFFF);
      run_capture("wrap", 100, 12'h800, 1'b0, -1, 0, -1, 1'b0, 9500);
      chk("wrap.addr_wrapped", saw_wrap, 1'b1);

      // 5: falling trigger, abort+start together in POST, then a fresh capture
      samp_pre = mk(12'hFFF, 12'h000);
      fill_rand(0, 300, 12'h900, 12'hFFF);
      fill_rand(300, NS, 0, 12'h3FF);
      run_capture("abort_post", 50, 12'h800, 1'b1, -1, 0, 400, 1'b0, 1000);
      samp_pre = mk(12'($urandom_range(4095, 0)), 12'h000);
      fill_rand(0, NS, 0, 12'hFFF);
      run_capture("resume", int'($urandom_range(200, 1)), 12'($urandom_range(4000, 100)),
                  1'($urandom_range(1, 0)), 3000, 0, -1, 1'b0, 9000);

      // reset in the middle of PRE
      fill_rand(0, NS, 0, 12'h7FF);
      run_capture("mid_reset", 30, 12'h800, 1'b0, -1, 0, 20, 1'b1, 100);

      // largest legal pretrig: trigger goes straight to DONE
      samp_pre = mk(12'h000, 12'h000);
      fill_rand(0, NS, 0, 12'h7FF);
      run_capture("pt_max", DEPTH - 1, 12'h800, 1'b0, 4100, 0, -1, 1'b0, 4300);

      // 6: timeout auto-trigger on a flat signal
      samp_pre = mk(12'h100, 12'h000);
      for (int j = 0; j < NS; j++) samp[j] = mk(12'h100, 12'($urandom_range(4095, 0)));
`ifdef ADC_TRIG_TIMEOUT_EN
      run_capture("timeout", 20, 12'h800, 1'b0, -1, 50, -1, 1'b0, 5000);
`else
      run_capture("no_timeout", 20, 12'h800, 1'b0, -1, 50, 20 + 10000, 1'b0, 10100);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
